// File: rtl/cam_timing_gen.sv
// Synthetic OV7670-style camera source: PCLK at CLK/2, plus VSYNC, HREF and an 8-bit
// test-pattern bus. Everything except PCLK changes only on PCLK falling edges.
module cam_timing_gen #(
  parameter int unsigned ACTIVE_COLS     = 640,
  parameter int unsigned BYTES_PER_PIXEL = 2,
  parameter int unsigned ACTIVE_ROWS     = 480,
  parameter int unsigned H_BLANK         = 144,
  parameter int unsigned VSYNC_LINES     = 3,
  parameter int unsigned V_BACK_LINES    = 17,
  parameter int unsigned V_FRONT_LINES   = 10
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [1:0]  PATTERN,
  output logic        PCLK,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  D,
  output logic [8:0]  ROW,
  output logic [10:0] COL,
  output logic        FRAME_DONE,
  output logic        BUSY
);

  localparam int unsigned HACT = ACTIVE_COLS * BYTES_PER_PIXEL;
  localparam int unsigned LLEN = HACT + H_BLANK;

  localparam logic [10:0] COL_LAST   = 11'(LLEN - 1);
  localparam logic [10:0] HACT_W     = 11'(HACT);
  localparam logic [8:0]  ROW_LAST   = 9'(ACTIVE_ROWS - 1);
  localparam logic [8:0]  VS_LAST    = 9'(VSYNC_LINES - 1);
  localparam logic [8:0]  BACK_LAST  = 9'(V_BACK_LINES - 1);
  localparam logic [8:0]  FRONT_LAST = 9'(V_FRONT_LINES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_BACK,
    ST_ACTIVE,
    ST_FRONT
  } state_t;

  state_t      state;
  logic        ph;
  logic [1:0]  pat;
  logic [8:0]  line_cnt;

  logic        col_wrap;
  logic [10:0] col_nx;
  logic [8:0]  row_nx;
  logic        href_nx;

  function automatic logic [7:0] pix(input logic [1:0] p, input logic [10:0] b,
                                     input logic [8:0] r);
    logic [7:0] v;
    case (p)
      2'd0:    v = b[7:0];
      2'd1:    v = r[7:0];
      2'd2:    v = b[0] ? 8'h5A : 8'hA5;
      default: v = (r[3] ^ b[4]) ? 8'hFF : 8'h00;
    endcase
    return v;
  endfunction

  assign PCLK = ph;

  always_comb begin
    col_wrap = (COL == COL_LAST);
    col_nx   = col_wrap ? '0 : COL + 11'd1;
    row_nx   = col_wrap ? ROW + 9'd1 : ROW;
    href_nx  = (col_nx < HACT_W);
  end

  // HREF and D are computed from the next COL/ROW so they land on the same tick as COL.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ph         <= 1'b0;
      state      <= ST_IDLE;
      pat        <= '0;
      line_cnt   <= '0;
      VSYNC      <= 1'b0;
      HREF       <= 1'b0;
      D          <= '0;
      ROW        <= '0;
      COL        <= '0;
      FRAME_DONE <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      ph         <= ~ph;
      FRAME_DONE <= 1'b0;
      if (ph) begin
        if (state != ST_IDLE) begin
          COL <= col_nx;
          if (col_wrap) line_cnt <= line_cnt + 9'd1;
        end
        case (state)
          ST_IDLE: begin
            if (START) begin
              state    <= ST_VSYNC;
              VSYNC    <= 1'b1;
              BUSY     <= 1'b1;
              COL      <= '0;
              ROW      <= '0;
              line_cnt <= '0;
              pat      <= PATTERN;
            end
          end
          ST_VSYNC: begin
            if (col_wrap && line_cnt == VS_LAST) begin
              state    <= ST_BACK;
              VSYNC    <= 1'b0;
              line_cnt <= '0;
            end
          end
          ST_BACK: begin
            if (col_wrap && line_cnt == BACK_LAST) begin
              state    <= ST_ACTIVE;
              line_cnt <= '0;
              ROW      <= '0;
              HREF     <= 1'b1;
              D        <= pix(pat, '0, '0);
            end
          end
          ST_ACTIVE: begin
            if (col_wrap && ROW == ROW_LAST) begin
              state    <= ST_FRONT;
              line_cnt <= '0;
              HREF     <= 1'b0;
              D        <= '0;
            end else begin
              ROW  <= row_nx;
              HREF <= href_nx;
              D    <= href_nx ? pix(pat, col_nx, row_nx) : '0;
            end
          end
          ST_FRONT: begin
            if (col_wrap && line_cnt == FRONT_LAST) begin
              FRAME_DONE <= 1'b1;
              line_cnt   <= '0;
              if (START) begin
                state <= ST_VSYNC;
                VSYNC <= 1'b1;
                ROW   <= '0;
                pat   <= PATTERN;
              end else begin
                state <= ST_IDLE;
                BUSY  <= 1'b0;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
